// File: rtl/fetch_stage_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : common_params (package)
// Purpose : Shared constants and helpers for the RV32I fetch stage.
//           XLEN          - datapath width
//           NOP_INSTR     - canonical NOP (addi x0, x0, 0)
//           DEFAULT_RESET_PC - reset fetch address used when none is given
//           align_word()  - force an address onto a 4-byte boundary
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package common_params;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Redirect targets are word addresses; the low two bits are discarded.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_ctrl_sat_counter.sv
//------------------------------------------------------------------------------
// Module  : sat_counter
// Purpose : Up-counter that sticks at all-ones instead of wrapping.
// Ports   : clk     - clock
//           rst     - asynchronous active-high reset (clears count)
//           i_en    - count this cycle
//           o_count - current count (registered)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sat_counter
  import common_params::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_stage_ctrl.sv
//------------------------------------------------------------------------------
// Module  : fetch_stage_ctrl
// Purpose : RV32I fetch-stage controller and IF/ID pipeline register.
//           Owns the PC, drives a synchronous instruction memory, holds the
//           decode instruction across stalls and squashes wrong-path fetches
//           on a taken redirect. Counts stall and flush cycles for debug.
// Ports   : clk, rst              - clock, async active-high reset
//           i_stall               - freeze PC and IF/ID (dominates flush)
//           i_flush               - redirect to i_id_branch_target
//           i_id_branch_target    - redirect address
//           o_imem_addr           - instruction memory address (= PC)
//           i_imem_rdata          - memory data for previous edge's address
//           o_if_id_pc            - PC of the decode instruction
//           o_if_id_pc_plus4      - o_if_id_pc + 4
//           o_if_id_instr         - decode instruction, NOP when invalid
//           o_if_id_valid         - decode slot holds a real instruction
//           o_stall_cnt           - saturating count of stalled cycles
//           o_flush_cnt           - saturating count of accepted flushes
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage_ctrl
  import common_params::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic [XLEN-1:0]  i_id_branch_target,
  output logic [XLEN-1:0]  o_imem_addr,
  input  logic [XLEN-1:0]  i_imem_rdata,
  output logic [XLEN-1:0]  o_if_id_pc,
  output logic [XLEN-1:0]  o_if_id_pc_plus4,
  output logic [XLEN-1:0]  o_if_id_instr,
  output logic             o_if_id_valid,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_id_pc;
  logic [XLEN-1:0] r_id_pc_plus4;
  logic            r_id_valid;
  logic [XLEN-1:0] r_hold_instr;
  logic            r_hold_valid;

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_target;
  logic            w_flush_take;

  assign w_pc_plus4   = r_pc + 32'd4;          // wraps modulo 2^32
  assign w_target     = align_word(i_id_branch_target);
  assign w_flush_take = i_flush & ~i_stall;    // a stall masks the flush

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_id_pc       <= '0;
      r_id_pc_plus4 <= 32'd4;
      r_id_valid    <= 1'b0;
      r_hold_instr  <= '0;
      r_hold_valid  <= 1'b0;
    end else if (i_stall) begin
      // PC stays put, so memory keeps re-reading the successor word. The
      // decode word only appears on rdata in the first stall cycle; latch it
      // then and replay it for the rest of the stall.
      if (!r_hold_valid) begin
        r_hold_instr <= i_imem_rdata;
        r_hold_valid <= 1'b1;
      end
    end else begin
      r_hold_valid  <= 1'b0;
      r_id_pc       <= r_pc;
      r_id_pc_plus4 <= w_pc_plus4;
      if (w_flush_take) begin
        // The word fetched at the old PC is on the wrong path: mark it
        // invalid in decode and start fetching the target.
        r_pc       <= w_target;
        r_id_valid <= 1'b0;
      end else begin
        r_pc       <= w_pc_plus4;
        r_id_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    o_if_id_instr = i_imem_rdata;
    if (!r_id_valid) begin
      o_if_id_instr = NOP_INSTR;
    end else if (r_hold_valid) begin
      o_if_id_instr = r_hold_instr;
    end
  end

  assign o_imem_addr      = r_pc;
  assign o_if_id_pc       = r_id_pc;
  assign o_if_id_pc_plus4 = r_id_pc_plus4;
  assign o_if_id_valid    = r_id_valid;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (i_stall),
    .o_count (o_stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_flush_take),
    .o_count (o_flush_cnt)
  );

endmodule

`default_nettype wire

// File: doc/fetch_stage_ctrl.md
# fetch_stage_ctrl

Fetch-stage controller and IF/ID pipeline register for the RV32I pipeline. It is the consumer of the hazard unit's STALL/FLUSH pair. It owns the PC and drives the synchronous instruction memory. It holds the decode-stage instruction stable across multi-cycle stalls, squashes wrong-path fetches on a taken branch/jump, and counts stall and flush cycles for debug.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `CNT_W`, default 32: width of the saturating stall/flush counters.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `STALL`  in  1  hazard-unit stall request: freeze PC and IF/ID.
- `FLUSH`  in  1  hazard-unit flush request: taken control flow resolved in decode.
- `ID_BRANCH_TARGET`  in  32  redirect address, valid when FLUSH=1.
- `IMEM_ADDR`  out  32  instruction-memory read address (= PC register).
- `IMEM_RDATA`  in  32  synchronous read data; reflects the address presented on the previous edge.
- `IF_ID_PC`  out  32  PC of the instruction in decode.
- `IF_ID_PC_PLUS4`  out  32  IF_ID_PC + 4.
- `IF_ID_INSTR`  out  32  instruction in decode; NOP when invalid.
- `IF_ID_VALID`  out  1  decode slot holds a real instruction.
- `STALL_CNT`  out  CNT_W  saturating count of cycles with STALL=1.
- `FLUSH_CNT`  out  CNT_W  saturating count of accepted flushes.

## Operation
- State:
  - `pc` is the address being fetched this cycle.
  - `id_pc` and `id_valid` describe the decode slot.
  - `hold_instr` and `hold_valid` form the stall replay buffer.
  - Two counters track stalls and flushes.
- Priority: STALL dominates FLUSH. A FLUSH asserted with STALL is ignored for that cycle.
- Normal advance (STALL=0, FLUSH=0):
  - pc <= pc+4
  - id_pc <= pc
  - id_valid <= 1
- Flush (STALL=0, FLUSH=1):
  - pc <= {ID_BRANCH_TARGET[31:2], 2'b00}
  - id_pc <= pc
  - id_valid <= 0, which squashes the wrong-path fetch of the old pc.
  - FLUSH_CNT increments.
- Stall (STALL=1):
  - pc, id_pc and id_valid are unchanged.
  - IMEM_ADDR stays at pc, so the memory re-reads the same word.
  - STALL_CNT increments.
- Replay buffer:
  - On the first stall cycle (hold_valid=0), hold_instr <= IMEM_RDATA and hold_valid <= 1.
  - hold_valid clears on any cycle with STALL=0.
- IF_ID_INSTR selection:
  - If ~id_valid, output 32'h0000_0013 (NOP).
  - Otherwise, if hold_valid, output hold_instr.
  - Otherwise, output IMEM_RDATA.
- Arithmetic:
  - PC+4 wraps modulo 2^32: 32'hFFFF_FFFC advances to 32'h0.
  - Counters saturate at all-ones and never wrap.

## Timing
- Reset values while rst=1:
  - pc=RESET_PC, so IMEM_ADDR=RESET_PC.
  - id_pc=0, id_valid=0, so IF_ID_INSTR=NOP and IF_ID_PC_PLUS4=4.
  - hold_valid=0, hold_instr=0.
  - Both counters = 0.
- Reset is asynchronous. It takes effect mid-stall or mid-flush with no residual state.
- Fetch latency is one cycle:
  - The address is presented in cycle t.
  - The instruction is in decode in t+1.
- Out of reset, the first valid decode is in the second cycle after rst deasserts, with IF_ID_PC=RESET_PC.
- Taken-branch penalty is exactly one bubble. The target instruction is in decode two cycles after the FLUSH cycle.
- Stall of N cycles:
  - The decode instruction, PC and valid stay constant for all N cycles.
  - The cycle after release shows the sequential successor.
  - No instruction is lost or duplicated.
- STALL and FLUSH together count a stall only. FLUSH_CNT does not change.
- All outputs except IF_ID_INSTR are registered. IF_ID_INSTR is a mux of registered state and IMEM_RDATA.

## Structure
- `common_params` package:
  - XLEN=32.
  - NOP_INSTR=32'h0000_0013.
  - Default reset PC constant.
- One natural sub-module, `sat_counter`, parameterised by CNT_W, with inputs en/clk/rst. It is instantiated twice.

## Test plan
- Reset release, RESET_PC=0, IMEM returning mem[a]=a|1:
  - First cycle after reset: IF_ID_VALID=0 and IF_ID_INSTR=NOP.
  - Then IF_ID_PC = 0, 4, 8 with matching instructions.
- FLUSH with target 32'h0000_0102 while pc=8:
  - Next cycle: IF_ID_VALID=0.
  - Following cycle: IF_ID_PC=0x100, IMEM_ADDR was 0x100, FLUSH_CNT=1.
- STALL held 3 cycles with instruction at 0x10 in decode:
  - IF_ID_INSTR and IF_ID_PC stay at mem[0x10]/0x10 all 3 cycles.
  - The cycle after release shows 0x14.
  - STALL_CNT=3.
- STALL=1 and FLUSH=1 simultaneously, then FLUSH alone:
  - First cycle: pc holds and FLUSH_CNT unchanged.
  - The redirect happens only in the FLUSH-only cycle.
- pc=32'hFFFF_FFFC advance:
  - IMEM_ADDR=0.
  - IF_ID_PC_PLUS4=0 when that instruction reaches decode.
- rst asserted during a stall with hold_valid=1:
  - All outputs return to reset values asynchronously.
  - After release, no stale hold_instr appears.
